vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Sequences the single-port video RAM that holds the 128x96 logical-pixel image.
- Shares the RAM between two requesters:
  - Display scan-out, driven by the vsync/hsync pixel counters. It has absolute priority.
  - A writer port (drawing engine / host) using a req/ack handshake.
- Fetches each logical pixel once, when the counters change.
- Presents the fetched colour to the RGB output stage.
- Fills the idle RAM cycles between fetches with writes.

Parameters:
H_PIXELS, 128, logical pixels per line (hpixel range 0..H_PIXELS-1)
V_PIXELS, 96, logical lines per frame (vpixel range 0..V_PIXELS-1)
ADDR_W, 14, RAM address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS
DATA_W, 3, pixel width (1 bit each R,G,B)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
disp_active  input  1  high while the beam is inside the visible window
disp_hpixel  input  7  current logical column
disp_vpixel  input  7  current logical row
wr_req  input  1  write request; held with wr_addr/wr_data stable until wr_ack
wr_addr  input  ADDR_W  linear write address (row*H_PIXELS + column)
wr_data  input  DATA_W  pixel to write
wr_ack  output  1  one-cycle pulse: write accepted (committed or dropped)
mem_addr  output  ADDR_W  RAM address
mem_en  output  1  RAM access enable
mem_we  output  1  RAM write enable
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data, valid the cycle after the read address is presented
pix_rgb  output  DATA_W  registered pixel colour to the DAC/pins
fetch_overrun  output  1  sticky: a new display address arrived while a fetch was pending

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - The last-fetched-address register is invalidated and the display-pending flag is cleared.
- Reset mid-operation:
  - The access in flight is abandoned.
  - No wr_ack is issued for an interrupted write; the writer re-issues it.
- Display request:
  - Raised when disp_active=1 and {disp_vpixel,disp_hpixel} differs from the last fetched pair, or the last fetched pair is invalid.
  - fetch_addr = disp_vpixel*H_PIXELS + disp_hpixel, computed at ADDR_W bits.
  - The pair is latched into a pending register.
- If a new pair arrives while one is already pending and not yet in RD:
  - The pending pair is overwritten by the newest pair.
  - fetch_overrun is set; it is cleared only by reset.
- FSM states: IDLE, RD, CAP, WR. Outputs are Moore-decoded from the state register.
  - IDLE: mem_en=0. If a display request is pending, go to RD. Otherwise, if wr_req=1, go to WR. Otherwise stay in IDLE. Display always beats the writer.
  - RD: mem_en=1, mem_we=0, mem_addr=pending fetch_addr. Clear the pending flag, record the pair as last fetched, go to CAP.
  - CAP: mem_en=0. pix_rgb<=mem_rdata at the end of this cycle. Go to IDLE.
  - WR: mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1. mem_en=mem_we=1 only if wr_addr < H_PIXELS*V_PIXELS; out-of-range writes are acked but dropped. Always go to IDLE.
- Latency: request detected at edge N; RD during cycle N+1; CAP during N+2; new pix_rgb visible from N+3.
- Write throughput: at most one write per 2 cycles, because WR->WR is forbidden. This prevents double-commit while the writer samples wr_ack.
- Simultaneous events:
  - Display request and wr_req both high in IDLE: RD wins; wr_req waits.
  - A display request raised during WR is served directly after the following IDLE cycle.
  - Worst-case display wait is 3 cycles, well under the 10-cycle logical-pixel period.
- Blanking:
  - When disp_active=0 at an edge, pix_rgb<=0 and the last-fetched pair is invalidated.
  - A CAP that coincides with disp_active=0 is discarded, and pix_rgb stays 0.
- A write to the currently displayed address takes effect on screen at the next fetch of that pixel. Pixels are not refetched.

Optional Feature:
Macro VRAM_ARB_STATS_EN.
- Defined: adds output port drop_cnt (16 bits).
  - Saturating count of out-of-range writes dropped in WR.
  - Reset value 0; holds at 16'hFFFF once reached.
- Not defined: the drop_cnt port and its counter are absent. Dropping behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with wr_req=1 and disp_active=1 -> all outputs 0, no wr_ack. Release reset -> first RD occurs within 2 cycles.
- Display fetch: RAM preloaded with addr 130 = 3'b101; set disp_active=1, vpixel=1, hpixel=2 -> mem_addr=130 with mem_en=1 at N+1, pix_rgb=3'b101 from N+3. Holding the pair for 10 cycles gives exactly one read.
- Priority: wr_req=1 (addr 5, data 3'b010) asserted in the same cycle a new pixel pair appears -> RD precedes WR. wr_ack pulses exactly once, 3 cycles later. RAM[5]=3'b010.
- Back-to-back writes: writer re-asserts wr_req the cycle after each ack, addrs 0..7, display idle -> 8 acks, spaced 2 cycles apart, no duplicate mem_we.
- Out-of-range: wr_addr=12288 -> wr_ack=1, mem_we=0, RAM unchanged. With VRAM_ARB_STATS_EN, drop_cnt increments 0->1.
- Blank/overrun: disp_active falls during CAP -> pix_rgb=0 next cycle. Changing the pixel pair on 2 consecutive cycles while in WR -> fetch_overrun=1 and stays 1 until reset.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port video RAM between display scan-out
// (absolute priority, one fetch per logical pixel) and a req/ack writer.
// Optional feature: define VRAM_ARB_STATS_EN to add the drop_cnt output,
// a saturating count of out-of-range writes that were acked but dropped.
module vram_arbiter #(
   parameter int H_PIXELS = 128,
   parameter int V_PIXELS = 96,
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_active,
   input  logic [6:0]        disp_hpixel,
   input  logic [6:0]        disp_vpixel,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] pix_rgb,
   output logic              fetch_overrun
`ifdef VRAM_ARB_STATS_EN
   ,
   output logic [15:0]       drop_cnt
`endif
);

   localparam int unsigned NPIX = H_PIXELS * V_PIXELS;

   typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

   state_t      state;
   logic [13:0] cur_pair;
   logic [13:0] pend_pair;
   logic [13:0] last_pair;
   logic        pend_vld;
   logic        last_vld;
   logic        disp_req;
   logic        wr_in_range;

   assign cur_pair = {disp_vpixel, disp_hpixel};

   // A pending pair is the newest one requested, so compare against it while
   // it is outstanding; otherwise compare against the last fetched pair.
   assign disp_req = disp_active &&
                     (pend_vld ? (cur_pair != pend_pair)
                               : (!last_vld || (cur_pair != last_pair)));

   assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(NPIX));

   function automatic logic [ADDR_W-1:0] pair_addr(input logic [13:0] p);
      return ADDR_W'(p[13:7]) * ADDR_W'(H_PIXELS) + ADDR_W'(p[6:0]);
   endfunction

   // Arbiter FSM; RAM strobes are registered on entry to each state so they
   // are a pure function of the state register during that cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         wr_ack        <= 1'b0;
         mem_addr      <= '0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_wdata     <= '0;
         pix_rgb       <= '0;
         fetch_overrun <= 1'b0;
         pend_pair     <= '0;
         last_pair     <= '0;
         pend_vld      <= 1'b0;
         last_vld      <= 1'b0;
`ifdef VRAM_ARB_STATS_EN
         drop_cnt      <= '0;
`endif
      end else begin
         wr_ack    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         case (state)
            IDLE: begin
               if (disp_req || pend_vld) begin
                  state    <= RD;
                  mem_en   <= 1'b1;
                  mem_addr <= pair_addr(disp_req ? cur_pair : pend_pair);
               end else if (wr_req) begin
                  state     <= WR;
                  wr_ack    <= 1'b1;
                  mem_addr  <= wr_addr;
                  mem_wdata <= wr_data;
                  mem_en    <= wr_in_range;
                  mem_we    <= wr_in_range;
`ifdef VRAM_ARB_STATS_EN
                  if (!wr_in_range && (drop_cnt != 16'hFFFF))
                     drop_cnt <= drop_cnt + 16'd1;
`endif
               end
            end
            RD: begin
               state     <= CAP;
               pend_vld  <= 1'b0;
               last_pair <= pend_pair;
               last_vld  <= 1'b1;
            end
            CAP: begin
               state   <= IDLE;
               pix_rgb <= disp_active ? mem_rdata : '0;
            end
            default: state <= IDLE;
         endcase
         // A new pair overrides the RD clear above; overwriting one that has
         // not reached RD yet is an overrun.
         if (disp_req) begin
            pend_pair <= cur_pair;
            pend_vld  <= 1'b1;
            if (pend_vld && (state != RD))
               fetch_overrun <= 1'b1;
         end
         // Blanking clears the output and forces a refetch on re-entry.
         if (!disp_active) begin
            pix_rgb  <= '0;
            last_vld <= 1'b0;
         end
      end
   end

endmodule
